instruction_fetch: RTL and testbench

Instruction fetch stage of the RV32I core: holds the program counter and issues word reads to instruction memory over a request/acknowledge handshake. It presents one fetched instruction at a time, with its PC and a valid flag, to the control_unit decoder directly downstream. It accepts stall and branch/jump redirects from later stages.

---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues word reads to
// instruction memory over a req/ack handshake and presents one instruction
// at a time, with its PC, to the decoder. Honours stall and redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_pending_pc;
  logic [31:0] r_instruction;
  logic [31:0] r_instr_pc;
  logic        r_misaligned;

  logic [31:0] w_target;
  logic        w_redirect_ok;
  logic        w_imem_req;
  logic        w_instr_valid;

  // Redirect targets are forced word aligned; IDLE ignores redirects.
  assign w_target      = {redirect_pc[31:2], 2'b00};
  assign w_redirect_ok = redirect && (r_state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: redirect outranks ack, ack outranks stall.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  w_state_next = FETCH;
      FETCH: begin
        if (imem_ack && !redirect) w_state_next = VALID;
        else if (redirect && !imem_ack) w_state_next = FLUSH;
      end
      VALID: begin
        if (redirect || !stall) w_state_next = FETCH;
      end
      FLUSH: begin
        if (imem_ack) w_state_next = FETCH;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: request only while a read is outstanding.
  always_comb begin
    w_imem_req    = (r_state == FETCH) || (r_state == FLUSH);
    w_instr_valid = (r_state == VALID);
  end

  // Datapath: fetch address, flush target, presented instruction and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_addr  <= RESET_PC;
      r_pending_pc  <= RESET_PC;
      r_instruction <= NOP;
      r_instr_pc    <= RESET_PC;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned <= w_redirect_ok && (redirect_pc[1:0] != 2'b00);
      unique case (r_state)
        FETCH: begin
          if (imem_ack && !redirect) begin
            r_instruction <= imem_rdata;
            r_instr_pc    <= r_fetch_addr;
            r_fetch_addr  <= r_fetch_addr + 32'd4;
          end else if (imem_ack && redirect) begin
            r_fetch_addr <= w_target;
          end else if (redirect) begin
            // Outstanding request must stay stable; park the target.
            r_pending_pc <= w_target;
          end
        end
        FLUSH: begin
          if (imem_ack) r_fetch_addr <= redirect ? w_target : r_pending_pc;
          else if (redirect) r_pending_pc <= w_target;
        end
        VALID: begin
          if (redirect) r_fetch_addr <= w_target;
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_fetch_addr;
  assign instruction = r_instruction;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = w_instr_valid;
  assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Transaction-level model: what is outstanding, whether its data will be
  // thrown away, where to resume, and what is being presented.
  bit          m_boot;     // first cycle after reset, nothing requested yet
  bit          m_req;      // a read is outstanding
  bit          m_drop;     // outstanding read's data will be discarded
  bit          m_valid;    // an instruction is being presented
  bit          m_mis;
  logic [31:0] m_addr;     // address of outstanding/next read
  logic [31:0] m_resume;   // where to fetch once the dropped read returns
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_8113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_boot   = 1'b1;
    m_req    = 1'b0;
    m_drop   = 1'b0;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
    m_addr   = RESET_PC;
    m_resume = RESET_PC;
    m_instr  = NOP;
    m_pc     = RESET_PC;
  endtask

  // Advance the model by one clock using the inputs that were on the pins.
  task automatic model_update();
    logic [31:0] tgt;
    bit          bad;
    tgt   = {redirect_pc[31:2], 2'b00};
    bad   = redirect && (redirect_pc[1:0] != 2'b00);
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_valid) begin
      m_mis = bad;
      if (redirect) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = tgt;
      end else if (!stall) begin
        m_valid = 1'b0; m_req = 1'b1;
      end
    end else if (m_req) begin
      m_mis = bad;
      if (m_drop) begin
        if (imem_ack) begin
          m_drop = 1'b0;
          m_addr = redirect ? tgt : m_resume;
        end else if (redirect) begin
          m_resume = tgt;
        end
      end else if (imem_ack && !redirect) begin
        m_valid = 1'b1; m_req = 1'b0;
        m_instr = imem_rdata; m_pc = m_addr;
        m_addr  = m_addr + 32'd4;
      end else if (imem_ack) begin
        m_addr = tgt;
      end else if (redirect) begin
        m_drop = 1'b1; m_resume = tgt;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model. Called and
  // returns 2 time units after a rising edge.
  task automatic cyc(input bit ack, input bit rd, input logic [31:0] rpc, input bit stl);
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(m_addr) : $urandom;
    redirect    = rd;
    redirect_pc = rpc;
    stall       = stl;
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #2;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_req", {31'd0, imem_req}, {31'd0, m_req});
      check("cmp_addr", imem_addr, m_addr);
      check("cmp_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check("cmp_instr", instruction, m_instr);
      check("cmp_pc", instr_pc, m_pc);
      check("cmp_mis", {31'd0, misaligned}, {31'd0, m_mis});
    end
  end

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state.
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Sequential fetch with zero-wait memory.
    cyc(0, 0, 0, 0);
    check("seq_req0", {31'd0, imem_req}, 32'd1);
    check("seq_addr0", imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    check("seq_valid0", {31'd0, instr_valid}, 32'd1);
    check("seq_instr0", instruction, 32'h0010_0093);
    check("seq_pc0", instr_pc, 32'h0);
    cyc(0, 0, 0, 0);
    check("seq_addr1", imem_addr, 32'h4);
    cyc(1, 0, 0, 0);
    check("seq_instr1", instruction, 32'h0020_8113);
    check("seq_pc1", instr_pc, 32'h4);
    cyc(0, 0, 0, 0);
    check("seq_addr2", imem_addr, 32'h8);

    // Wait states: ack on the fourth request cycle.
    for (int i = 0; i < 3; i++) begin
      check("ws_req", {31'd0, imem_req}, 32'd1);
      check("ws_addr", imem_addr, 32'h8);
      cyc(0, 0, 0, 0);
    end
    check("ws_addr_last", imem_addr, 32'h8);
    cyc(1, 0, 0, 0);
    check("ws_valid", {31'd0, instr_valid}, 32'd1);
    check("ws_pc", instr_pc, 32'h8);

    // Stall for five cycles, including a stray ack that must be ignored.
    for (int i = 0; i < 5; i++) begin
      cyc(i == 2, 0, 0, 1);
      check("st_valid", {31'd0, instr_valid}, 32'd1);
      check("st_req", {31'd0, imem_req}, 32'd0);
      check("st_pc", instr_pc, 32'h8);
      check("st_instr", instruction, mem_word(32'h8));
    end
    cyc(0, 0, 0, 0);
    check("st_next_addr", imem_addr, 32'hC);
    check("st_next_req", {31'd0, imem_req}, 32'd1);

    // Redirect to 0x40 two cycles before the ack of the read at 0xC.
    cyc(0, 1, 32'h40, 0);
    check("fl_addr_hold", imem_addr, 32'hC);
    cyc(0, 0, 0, 0);
    check("fl_addr_hold2", imem_addr, 32'hC);
    cyc(1, 0, 0, 0);
    check("fl_dropped", {31'd0, instr_valid}, 32'd0);
    check("fl_new_addr", imem_addr, 32'h40);
    cyc(1, 0, 0, 0);
    check("fl_pc", instr_pc, 32'h40);
    cyc(0, 0, 0, 0);

    // Misaligned redirect with a same-cycle ack, then wrap at the top.
    cyc(1, 1, 32'h0000_0102, 0);
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_novalid", {31'd0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    check("mis_clear", {31'd0, misaligned}, 32'd0);
    cyc(1, 1, 32'hFFFF_FFFC, 0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_next", imem_addr, 32'h0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset while a request is outstanding, late ack after.
    rst = 1'b1;
    model_reset();
    #1;
    check("ar_req", {31'd0, imem_req}, 32'd0);
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_instr", instruction, 32'h0000_0013);
    #1;
    cyc(1, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 0, 0, 0);
    check("ar_restart_req", {31'd0, imem_req}, 32'd1);
    check("ar_restart_addr", imem_addr, RESET_PC);
    check("ar_late_ack", {31'd0, instr_valid}, 32'd0);
    check("ar_pc", instr_pc, RESET_PC);

    // Randomized traffic; the negedge process checks against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("rnd_ar_req", {31'd0, imem_req}, 32'd0);
        #1;
        cyc($urandom_range(0, 1) == 0, 0, 0, 0);
        rst = 1'b0;
      end
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF8 | ($urandom & 32'h7);
      cyc(m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
          $urandom_range(0, 7) == 0, rpc, $urandom_range(0, 1) == 1);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
